// File: rtl/fft_addr_gen.sv
// Radix-2 in-place FFT butterfly address sequencer: walks every stage/butterfly and
// emits upper-leg address, leg span, twiddle index and stage tags over a valid/ready link.
module fft_addr_gen #(
  parameter int LOG2N      = 10,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] op_a,
  output logic [ADDR_WIDTH-1:0] op_b,
  output logic [LOG2N-2:0]      tw_idx,
  output logic [3:0]            stage_idx,
  output logic                  stage_last,
  output logic                  busy,
  output logic                  done
);

  localparam int              KW     = LOG2N - 1;
  localparam logic [KW-1:0]   K_LAST = '1;
  localparam logic [3:0]      S_LAST = 4'(LOG2N - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_s, w_s_nxt;
  logic [KW-1:0]         r_k, w_k_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  w_load, w_clear;
  logic [ADDR_WIDTH-1:0] r_op_a, r_op_b;
  logic [KW-1:0]         r_tw;
  logic [3:0]            r_stage;
  logic                  r_last;

  logic [ADDR_WIDTH-1:0] w_k_ext, w_mask, w_pos, w_op_a, w_op_b;
  logic [3:0]            w_tw_sh;
  logic [KW-1:0]         w_tw;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_k_nxt     = r_k;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_s_nxt     = '0;
      w_k_nxt     = '0;
      w_valid_nxt = 1'b0;
      w_busy_nxt  = 1'b0;
      w_clear     = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt = ST_RUN;
            w_s_nxt     = '0;
            w_k_nxt     = '0;
            w_valid_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
            w_load      = 1'b1;
          end
        end
        ST_RUN: begin
          if (r_valid && out_ready) begin
            if (r_k != K_LAST) begin
              w_k_nxt = r_k + KW'(1);
              w_load  = 1'b1;
            end else if (r_s != S_LAST) begin
              w_k_nxt = '0;
              w_s_nxt = r_s + 4'd1;
              w_load  = 1'b1;
            end else begin
              // Last butterfly of last stage accepted; the operand registers keep their final values.
              w_state_nxt = ST_DONE;
              w_s_nxt     = '0;
              w_k_nxt     = '0;
              w_valid_nxt = 1'b0;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
            end
          end
        end
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Butterfly addressing for the counters being loaded: op_a inserts a zero at bit s of k.
  assign w_k_ext = ADDR_WIDTH'(w_k_nxt);
  assign w_op_b  = ADDR_WIDTH'(1) << w_s_nxt;
  assign w_mask  = w_op_b - ADDR_WIDTH'(1);
  assign w_pos   = w_k_ext & w_mask;
  assign w_op_a  = ((w_k_ext >> w_s_nxt) << (w_s_nxt + 4'd1)) | w_pos;
  assign w_tw_sh = S_LAST - w_s_nxt;
  assign w_tw    = KW'(w_pos << w_tw_sh);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_k     <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_tw    <= '0;
      r_stage <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_k     <= w_k_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      if (w_clear) begin
        r_op_a  <= '0;
        r_op_b  <= '0;
        r_tw    <= '0;
        r_stage <= '0;
        r_last  <= 1'b0;
      end else if (w_load) begin
        r_op_a  <= w_op_a;
        r_op_b  <= w_op_b;
        r_tw    <= w_tw;
        r_stage <= w_s_nxt;
        r_last  <= (w_k_nxt == K_LAST);
      end
    end
  end

  assign out_valid  = r_valid;
  assign op_a       = r_op_a;
  assign op_b       = r_op_b;
  assign tw_idx     = r_tw;
  assign stage_idx  = r_stage;
  assign stage_last = r_last;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Directed bench for fft_addr_gen: an 8-point instance for sequence/handshake/abort/reset
// scenarios and a default 1024-point instance for the full-length run.
module tb_fft_addr_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start3, abort3, rdy3;
  logic        v3, last3, busy3, done3;
  logic [11:0] a3, b3;
  logic [1:0]  tw3;
  logic [3:0]  st3;

  logic        start10, abort10, rdy10;
  logic        v10, last10, busy10, done10;
  logic [11:0] a10, b10;
  logic [8:0]  tw10;
  logic [3:0]  st10;

  fft_addr_gen #(.LOG2N(3), .ADDR_WIDTH(12)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .out_ready(rdy3),
    .out_valid(v3), .op_a(a3), .op_b(b3), .tw_idx(tw3), .stage_idx(st3),
    .stage_last(last3), .busy(busy3), .done(done3));

  fft_addr_gen dut10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .abort(abort10), .out_ready(rdy10),
    .out_valid(v10), .op_a(a10), .op_b(b10), .tw_idx(tw10), .stage_idx(st10),
    .stage_last(last10), .busy(busy10), .done(done10));

  int n_checks = 0;
  int n_fails  = 0;

  // Hand-computed 8-point sequence
  int exp_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b  [12] = '{1, 1, 1, 1, 2, 2, 2, 2, 4, 4, 4, 4};
  int exp_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  logic [31:0] obs3;
  assign obs3 = {v3, a3, b3, tw3, st3, last3};

  function automatic logic [31:0] exp_set3(input int i);
    return {1'b1, 12'(exp_a[i]), 12'(exp_b[i]), 2'(exp_tw[i]), 4'(i / 4), (i % 4 == 3)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start3 = 1'b0; abort3 = 1'b0; rdy3 = 1'b1;
    start10 = 1'b0; abort10 = 1'b0; rdy10 = 1'b1;
    #3;
    n_checks++;
    if ({obs3, busy3, done3} !== 34'd0) begin
      n_fails++;
      $display("FAIL reset_dut3: got %h expected 0", {obs3, busy3, done3});
    end
    n_checks++;
    if ({v10, a10, b10, tw10, st10, last10, busy10, done10} !== 41'd0) begin
      n_fails++;
      $display("FAIL reset_dut10: got %h expected 0",
               {v10, a10, b10, tw10, st10, last10, busy10, done10});
    end
    #4 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    rdy3 = 1'b1;
    n_checks++;
    if (v3 !== 1'b0) begin
      n_fails++;
      $display("FAIL basic_pre_valid: got %b expected 0", v3);
    end
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (obs3 !== exp_set3(i)) begin
        n_fails++;
        $display("FAIL basic_set%0d: got %h expected %h", i, obs3, exp_set3(i));
      end
      n_checks++;
      if ({busy3, done3} !== 2'b10) begin
        n_fails++;
        $display("FAIL basic_busy%0d: got %b expected 10", i, {busy3, done3});
      end
      step();
    end
    n_checks++;
    if ({v3, busy3, done3} !== 3'b001) begin
      n_fails++;
      $display("FAIL basic_done: got %b expected 001", {v3, busy3, done3});
    end
    step();
    n_checks++;
    if ({v3, busy3, done3} !== 3'b000) begin
      n_fails++;
      $display("FAIL basic_idle: got %b expected 000", {v3, busy3, done3});
    end
  endtask

  task automatic test_stall();
    logic [7:0] lfsr = 8'hA5;
    int idx = 0;
    int cyc = 0;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    while (idx < 12 && cyc < 200) begin
      n_checks++;
      if (obs3 !== exp_set3(idx)) begin
        n_fails++;
        $display("FAIL stall_set%0d_cyc%0d: got %h expected %h", idx, cyc, obs3, exp_set3(idx));
      end
      n_checks++;
      if ({busy3, done3} !== 2'b10) begin
        n_fails++;
        $display("FAIL stall_busy_cyc%0d: got %b expected 10", cyc, {busy3, done3});
      end
      rdy3 = lfsr[0];
      if (rdy3) idx++;
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      step();
      cyc++;
    end
    rdy3 = 1'b1;
    n_checks++;
    if (idx != 12) begin
      n_fails++;
      $display("FAIL stall_timeout: got %0d transfers expected 12", idx);
    end
    n_checks++;
    if ({v3, busy3, done3} !== 3'b001) begin
      n_fails++;
      $display("FAIL stall_done: got %b expected 001", {v3, busy3, done3});
    end
    step();
  endtask

  task automatic test_restart_ignored();
    int done_seen = 0;
    rdy3 = 1'b1;
    start3 = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (obs3 !== exp_set3(i)) begin
        n_fails++;
        $display("FAIL restart_set%0d: got %h expected %h", i, obs3, exp_set3(i));
      end
      if (done3) done_seen++;
      start3 = (i % 2 == 0);
      step();
    end
    n_checks++;
    if ({v3, busy3, done3} !== 3'b001) begin
      n_fails++;
      $display("FAIL restart_done: got %b expected 001", {v3, busy3, done3});
    end
    if (done3) done_seen++;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (done3) done_seen++;
      n_checks++;
      if ({v3, busy3} !== 2'b00) begin
        n_fails++;
        $display("FAIL restart_idle%0d: got %b expected 00", j, {v3, busy3});
      end
      step();
    end
    n_checks++;
    if (done_seen != 1) begin
      n_fails++;
      $display("FAIL restart_done_count: got %0d expected 1", done_seen);
    end
  endtask

  task automatic test_abort();
    rdy3 = 1'b1;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (obs3 !== exp_set3(i)) begin
        n_fails++;
        $display("FAIL abort_set%0d: got %h expected %h", i, obs3, exp_set3(i));
      end
      step();
    end
    abort3 = 1'b1;
    step();
    abort3 = 1'b0;
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if ({v3, busy3, done3} !== 3'b000) begin
        n_fails++;
        $display("FAIL abort_idle%0d: got %b expected 000", j, {v3, busy3, done3});
      end
      step();
    end
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    n_checks++;
    if ({v3, a3, b3, st3} !== {1'b1, 12'd0, 12'd1, 4'd0}) begin
      n_fails++;
      $display("FAIL abort_restart: got v=%b a=%0d b=%0d s=%0d expected v=1 a=0 b=1 s=0",
               v3, a3, b3, st3);
    end
    abort3 = 1'b1;
    step();
    abort3 = 1'b0;
    n_checks++;
    if (v3 !== 1'b0) begin
      n_fails++;
      $display("FAIL abort_second: got %b expected 0", v3);
    end
    abort3 = 1'b1;
    start3 = 1'b1;
    step();
    abort3 = 1'b0;
    start3 = 1'b0;
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if ({v3, busy3, done3} !== 3'b000) begin
        n_fails++;
        $display("FAIL abort_with_start%0d: got %b expected 000", j, {v3, busy3, done3});
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    rdy3 = 1'b1;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int i = 0; i < 6; i++) step();
    n_checks++;
    if (obs3 !== exp_set3(6)) begin
      n_fails++;
      $display("FAIL areset_pre: got %h expected %h", obs3, exp_set3(6));
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({obs3, busy3, done3} !== 34'd0) begin
      n_fails++;
      $display("FAIL areset_immediate: got %h expected 0", {obs3, busy3, done3});
    end
    #3 rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      n_checks++;
      if ({v3, busy3, done3} !== 3'b000) begin
        n_fails++;
        $display("FAIL areset_idle%0d: got %b expected 000", j, {v3, busy3, done3});
      end
    end
  endtask

  task automatic test_full_default();
    int cyc = 0;
    int xfers = 0;
    int lasts = 0;
    rdy10 = 1'b1;
    start10 = 1'b1;
    step();
    start10 = 1'b0;
    while (done10 !== 1'b1 && cyc < 6000) begin
      if (v10) begin
        if (xfers == 0 || xfers == 512 || xfers == 513 || xfers == 5119) begin
          logic [36:0] want;
          case (xfers)
            0:       want = {12'd0,   12'd1,   9'd0,   4'd0};
            512:     want = {12'd0,   12'd2,   9'd0,   4'd1};
            513:     want = {12'd1,   12'd2,   9'd256, 4'd1};
            default: want = {12'd511, 12'd512, 9'd511, 4'd9};
          endcase
          n_checks++;
          if ({a10, b10, tw10, st10} !== want) begin
            n_fails++;
            $display("FAIL full_set%0d: got a=%0d b=%0d tw=%0d s=%0d expected %h",
                     xfers, a10, b10, tw10, st10, want);
          end
        end
        if (last10) lasts++;
        xfers++;
      end
      step();
      cyc++;
    end
    n_checks++;
    if (cyc != 5120) begin
      n_fails++;
      $display("FAIL full_done_cycle: got %0d expected 5120", cyc);
    end
    n_checks++;
    if (xfers != 5120) begin
      n_fails++;
      $display("FAIL full_transfers: got %0d expected 5120", xfers);
    end
    n_checks++;
    if (lasts != 10) begin
      n_fails++;
      $display("FAIL full_stage_last: got %0d expected 10", lasts);
    end
    n_checks++;
    if ({v10, busy10} !== 2'b00) begin
      n_fails++;
      $display("FAIL full_end_state: got %b expected 00", {v10, busy10});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_restart_ignored();
    test_abort();
    test_async_reset();
    test_full_default();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
